// File: rtl/gf180mcu_ocd_io__pwr_seq_pkg.sv
// Shared state encoding and sizing helpers for the I/O ring power sequencer.
package gf180mcu_ocd_io__pwr_seq_pkg;

  typedef enum logic [2:0] {
    S_OFF,
    S_RAMP,
    S_SETTLE,
    S_ON,
    S_DOWN,
    S_FLT
  } pwr_state_e;

  localparam int FAULT_SEG_W = 3;

  function automatic int cnt_width(input int timeout_cyc, input int settle_cyc,
                                   input int down_cyc);
    int m;
    m = timeout_cyc;
    if (settle_cyc > m) m = settle_cyc;
    if (down_cyc > m) m = down_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__pg_sync.sv
// N_SEG-wide two-flop synchronizer for asynchronous segment power-good inputs.
module gf180mcu_ocd_io__pg_sync #(
  parameter int N_SEG = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SEG-1:0] pg_i,
  output logic [N_SEG-1:0] pg_s_o
);

  logic [N_SEG-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= pg_i;
      sync_q <= meta_q;
    end
  end

  assign pg_s_o = sync_q;

endmodule

// File: rtl/gf180mcu_ocd_io__pwr_seq.sv
// I/O pad ring power sequencer: segment-by-segment bring-up, fault latch, staged power-down.
// Define GF180MCU_OCD_IO_PG_SYNC_EN to route PG through a 2-flop synchronizer.
module gf180mcu_ocd_io__pwr_seq
  import gf180mcu_ocd_io__pwr_seq_pkg::*;
#(
  parameter int N_SEG       = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int SETTLE_CYC  = 16,
  parameter int DOWN_CYC    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   shutdown_i,
  input  logic                   clr_fault_i,
  input  logic [N_SEG-1:0]       pg_i,
  output logic [N_SEG-1:0]       seg_en_o,
  output logic                   io_iso_o,
  output logic                   ready_o,
  output logic                   fault_o,
  output logic [FAULT_SEG_W-1:0] fault_seg_o
);

  localparam int                     CNT_W    = cnt_width(TIMEOUT_CYC, SETTLE_CYC, DOWN_CYC);
  localparam logic [CNT_W-1:0]       TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]       SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]       DN_LAST  = CNT_W'(DOWN_CYC - 1);
  localparam logic [N_SEG-1:0]       SEG_ONE  = N_SEG'(1);
  localparam logic [FAULT_SEG_W-1:0] LAST_IDX = FAULT_SEG_W'(N_SEG - 1);

  pwr_state_e             state_q;
  logic [FAULT_SEG_W-1:0] idx_q, fault_seg_q, flt_seg;
  logic [CNT_W-1:0]       cnt_q, cnt_inc;
  logic [N_SEG-1:0]       seg_en_q, pg_s, chk_mask, bad, cur_bit, top_bit;
  logic                   io_iso_q, ready_q, fault_q;
  logic                   pg_cur, go_flt;

`ifdef GF180MCU_OCD_IO_PG_SYNC_EN
  gf180mcu_ocd_io__pg_sync #(.N_SEG(N_SEG)) u_pg_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pg_i   (pg_i),
    .pg_s_o (pg_s)
  );
`else
  assign pg_s = pg_i;
`endif

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Rails already brought up must stay good; the one being ramped is only
  // checked once it has reported PG (SETTLE/ON).
  always_comb begin
    chk_mask = '0;
    for (int j = 0; j < N_SEG; j++)
      chk_mask[j] = (j < int'(idx_q)) || ((j == int'(idx_q)) && (state_q != S_RAMP));
    if (!(state_q inside {S_RAMP, S_SETTLE, S_ON})) chk_mask = '0;
    bad     = chk_mask & ~pg_s;
    cur_bit = SEG_ONE << idx_q;
    pg_cur  = |(pg_s & cur_bit);
    flt_seg = idx_q;
    for (int j = N_SEG - 1; j >= 0; j--)
      if (bad[j]) flt_seg = FAULT_SEG_W'(j);
    go_flt = (|bad) || ((state_q == S_RAMP) && !pg_cur && (cnt_q == TO_LAST));
    top_bit = '0;
    for (int j = 0; j < N_SEG; j++)
      if (seg_en_q[j]) top_bit = SEG_ONE << j;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_OFF;
      idx_q       <= '0;
      cnt_q       <= '0;
      seg_en_q    <= '0;
      io_iso_q    <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      fault_seg_q <= '0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (start_i && !shutdown_i) begin
            state_q  <= S_RAMP;
            idx_q    <= '0;
            cnt_q    <= '0;
            seg_en_q <= SEG_ONE;
          end
        end
        S_RAMP, S_SETTLE, S_ON: begin
          if (go_flt) begin
            state_q     <= S_FLT;
            seg_en_q    <= '0;
            io_iso_q    <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b1;
            fault_seg_q <= flt_seg;
            cnt_q       <= '0;
          end else if (shutdown_i) begin
            state_q  <= S_DOWN;
            io_iso_q <= 1'b1;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
          end else if (state_q == S_RAMP) begin
            if (pg_cur) begin
              state_q <= S_SETTLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else if (state_q == S_SETTLE) begin
            if (cnt_q == SET_LAST) begin
              cnt_q <= '0;
              if (idx_q == LAST_IDX) begin
                state_q  <= S_ON;
                io_iso_q <= 1'b0;
                ready_q  <= 1'b1;
              end else begin
                state_q  <= S_RAMP;
                idx_q    <= idx_q + 1'b1;
                seg_en_q <= seg_en_q | (cur_bit << 1);
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        S_DOWN: begin
          if (cnt_q == DN_LAST) begin
            cnt_q    <= '0;
            seg_en_q <= seg_en_q & ~top_bit;
            if ((seg_en_q & ~top_bit) == '0) state_q <= S_OFF;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_FLT: begin
          if (clr_fault_i) begin
            state_q <= S_OFF;
            fault_q <= 1'b0;
          end
        end
        default: state_q <= S_OFF;
      endcase
    end
  end

  assign seg_en_o    = seg_en_q;
  assign io_iso_o    = io_iso_q;
  assign ready_o     = ready_q;
  assign fault_o     = fault_q;
  assign fault_seg_o = fault_seg_q;

endmodule

// File: tb/tb_gf180mcu_ocd_io__pwr_seq.sv
// Self-checking bench: directed and randomized power-up/down/fault sequences against a timeline model.
module tb_gf180mcu_ocd_io__pwr_seq;

  localparam int N  = 4;
  localparam int TO = 20;
  localparam int ST = 4;
  localparam int DN = 3;
`ifdef GF180MCU_OCD_IO_PG_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, shutdown, clr_fault;
  logic [N-1:0] pg, seg_en;
  logic         iso, ready, fault;
  logic [2:0]   fseg;
  logic [2:0]   m_fseg;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  gf180mcu_ocd_io__pwr_seq #(
    .N_SEG(N), .TIMEOUT_CYC(TO), .SETTLE_CYC(ST), .DOWN_CYC(DN)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .shutdown_i  (shutdown),
    .clr_fault_i (clr_fault),
    .pg_i        (pg),
    .seg_en_o    (seg_en),
    .io_iso_o    (iso),
    .ready_o     (ready),
    .fault_o     (fault),
    .fault_seg_o (fseg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected view: n_en low segments enabled, isolation is the inverse of ready.
  task automatic expect_out(input string tag, input int k, input int n_en,
                            input logic e_ready, input logic e_fault);
    logic [N+5:0] obs, exp;
    logic [N-1:0] e_seg;
    e_seg = '0;
    for (int i = 0; i < n_en; i++) e_seg[i] = 1'b1;
    obs = {fseg, fault, ready, iso, seg_en};
    exp = {m_fseg, e_fault, e_ready, !e_ready, e_seg};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d fseg/fault/ready/iso/seg_en observed=%b expected=%b",
             tag, k, obs, exp);
    end
  endtask

  // Segment i is enabled at t[i]; its PG is raised d[i] cycles later.
  // fail_seg >= N means every PG eventually rises.
  task automatic run_up(input string tag, input int d[N], input int fail_seg);
    int t[N];
    int t_on, t_end, n_en;
    t[0] = 0;
    for (int i = 1; i < N; i++) t[i] = t[i-1] + d[i-1] + 1 + SYNC + ST;
    t_on  = t[N-1] + d[N-1] + 1 + SYNC + ST;
    t_end = (fail_seg < N) ? t[fail_seg] + TO : t_on + 2;
    pg = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= t_end; k++) begin
      if (k > 0) tick();
      for (int i = 0; i < N; i++)
        if (i < fail_seg && k >= t[i] + d[i]) pg[i] = 1'b1;
      n_en = 0;
      for (int i = 0; i < N; i++)
        if (i <= fail_seg && k >= t[i]) n_en++;
      if (fail_seg < N && k == t_end) begin
        m_fseg = 3'(fail_seg);
        expect_out(tag, k, 0, 1'b0, 1'b1);
      end else begin
        expect_out(tag, k, n_en, (fail_seg >= N) && (k >= t_on), 1'b0);
      end
    end
  endtask

  task automatic clear_fault(input string tag);
    pg = '0;
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    expect_out(tag, 0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      expect_out(tag, k, 0, 1'b0, 1'b0);
    end
  endtask

  // One-cycle PG drop on the masked segments while ON; optional simultaneous SHUTDOWN.
  task automatic brownout(input string tag, input logic [N-1:0] mask, input logic sd);
    int low;
    low = 0;
    for (int i = N - 1; i >= 0; i--) if (mask[i]) low = i;
    pg = pg & ~mask;
    for (int s = 0; s <= SYNC; s++) begin
      shutdown = sd && (s == SYNC);
      tick();
      pg = '1;
      if (s < SYNC) expect_out(tag, s, N, 1'b1, 1'b0);
    end
    shutdown = 1'b0;
    m_fseg = 3'(low);
    expect_out(tag, SYNC + 1, 0, 1'b0, 1'b1);
    clear_fault(tag);
  endtask

  // SHUTDOWN from ON; START held during the first part of DOWN must be ignored.
  task automatic power_down(input string tag);
    int n;
    shutdown = 1'b1;
    tick();
    shutdown = 1'b0;
    expect_out(tag, 0, N, 1'b0, 1'b0);
    pg = '0;
    start = 1'b1;
    for (int k = 1; k <= DN * N + 3; k++) begin
      tick();
      if (k == 2 * DN) start = 1'b0;
      n = N - k / DN;
      if (n < 0) n = 0;
      expect_out(tag, k, n, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int d[N];
    int fs;
    rst = 1'b1; start = 1'b0; shutdown = 1'b0; clr_fault = 1'b0; pg = '0;
    m_fseg = '0;
    tick();
    tick();
    expect_out("reset", 0, 0, 1'b0, 1'b0);
    rst = 1'b0;

    d = '{5, 5, 5, 5};
    run_up("nominal_up", d, N);
    power_down("shutdown");

    pg = '0; start = 1'b1; shutdown = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("start_vs_shutdown", k, 0, 1'b0, 1'b0);
    end
    start = 1'b0; shutdown = 1'b0;

    d = '{$urandom_range(0, 8), $urandom_range(0, 8), 0, 0};
    run_up("timeout_seg2", d, 2);
    clear_fault("timeout_clr");

    pg = '0; start = 1'b1;
    tick();
    start = 1'b0;
    expect_out("rst_ramp", 0, 1, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_fseg = '0;
    expect_out("rst_ramp", 3, 0, 1'b0, 1'b0);
    tick();
    tick();
    expect_out("rst_ramp", 5, 0, 1'b0, 1'b0);

    d = '{5, 5, 5, 5};
    run_up("up_b", d, N);
    brownout("brownout_pg1", 4'b0010, 1'b0);

    d = '{2, 0, 7, 3};
    run_up("up_c", d, N);
    brownout("fault_vs_shutdown", 4'(1 << $urandom_range(0, N - 1)), 1'b1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) d[i] = $urandom_range(0, 8);
      fs = $urandom_range(0, N + 1);
      if (fs >= N) fs = N;
      run_up("rand_up", d, fs);
      if (fs < N) clear_fault("rand_clr");
      else if ($urandom_range(0, 1) == 0) power_down("rand_down");
      else brownout("rand_brownout", 4'($urandom_range(1, (1 << N) - 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
